// File: rtl/wb_pkg.sv
// Shared types for the write-back stage.
// LSU operation encoding seen by WB.
package wb_pkg;

  typedef enum logic {
    LSU_OP_LD = 1'b0,
    LSU_OP_ST = 1'b1
  } lsu_op_e;

endpackage

// File: rtl/wb_stage.sv
// Write-back stage: commits results, waits on LSU responses,
// reports LSU faults and counts retired instructions.
module wb_stage
  import wb_pkg::*;
#(
  parameter int unsigned TAG_WIDTH      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_wr_en_wb,
  input  logic [TAG_WIDTH-1:0] rd_wr_tag_wb,
  input  logic [4:0]           rd_wr_addr_wb,
  input  logic [31:0]          rd_wr_data_wb,
  input  logic                 lsu_en_wb,
  input  lsu_op_e              lsu_op_wb,
  input  logic [31:0]          lsu_rdata_wb,
  input  logic                 lsu_valid_wb,
  input  logic                 lsu_err_wb,
  input  logic                 exc_taken_wb,
  input  logic [31:0]          pc_wb,
  input  logic                 iretire_wb,
  output logic                 ready_wb,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic                 forward_wb_en,
  output logic [TAG_WIDTH-1:0] forward_wb_tag,
  output logic [4:0]           forward_wb_addr,
  output logic [31:0]          forward_wb_wdata,
  output logic                 clr_dirty_wb_en,
  output logic [4:0]           clr_dirty_wb_addr,
  output logic                 lsu_exc_o,
  output logic [3:0]           lsu_exc_cause,
  output logic [31:0]          lsu_exc_pc,
  output logic                 retire_o,
  output logic [63:0]          minstret
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam bit TMO_ON = (TIMEOUT_CYCLES != 0);

  state_e        state_q, state_d;
  logic          pend_ret_q, pend_ret_d;
  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [63:0]   minstret_q, minstret_d;

  logic need_wait;
  logic tmo_hit;
  logic complete;
  logic ret_src;
  logic fault;
  logic is_ld;
  logic [31:0] wdata;

  assign minstret = minstret_q;

  // Next state, completion decode and all stage outputs.
  always_comb begin
    state_d    = state_q;
    pend_ret_d = pend_ret_q;
    tmo_cnt_d  = tmo_cnt_q;
    ready_wb   = 1'b1;
    complete   = 1'b0;
    ret_src    = 1'b0;
    fault      = 1'b0;
    rf_we          = 1'b0;
    rf_waddr       = '0;
    rf_wdata       = '0;
    lsu_exc_o      = 1'b0;
    lsu_exc_cause  = '0;
    lsu_exc_pc     = '0;
    retire_o       = 1'b0;

    need_wait = lsu_en_wb & ~exc_taken_wb;
    is_ld     = lsu_en_wb & (lsu_op_wb == LSU_OP_LD);
    wdata     = is_ld ? lsu_rdata_wb : rd_wr_data_wb;
    tmo_hit   = TMO_ON & (state_q == S_WAIT) &
                (tmo_cnt_q == TMO_LAST);

    unique case (state_q)
      S_IDLE: begin
        if (need_wait & ~lsu_valid_wb) begin
          state_d    = S_WAIT;
          ready_wb   = 1'b0;
          pend_ret_d = iretire_wb;
          tmo_cnt_d  = '0;
        end else begin
          complete = 1'b1;
          ret_src  = iretire_wb;
        end
      end
      S_WAIT: begin
        if (lsu_valid_wb | tmo_hit) begin
          complete = 1'b1;
          ret_src  = pend_ret_q;
          state_d  = S_IDLE;
        end else begin
          ready_wb  = 1'b0;
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (complete) begin
      fault = (need_wait & lsu_valid_wb & lsu_err_wb) | tmo_hit;
      rf_we = rd_wr_en_wb & ~exc_taken_wb & ~fault;
      if (rf_we) begin
        rf_waddr = rd_wr_addr_wb;
        rf_wdata = wdata;
      end
      if (fault) begin
        lsu_exc_o     = 1'b1;
        lsu_exc_cause = is_ld ? 4'd5 : 4'd7;
        lsu_exc_pc    = pc_wb;
      end
      retire_o = ret_src & ~fault & ~exc_taken_wb;
    end

    // Outputs sit at their idle values while reset is held.
    if (reset) begin
      ready_wb      = 1'b1;
      rf_we         = 1'b0;
      rf_waddr      = '0;
      rf_wdata      = '0;
      lsu_exc_o     = 1'b0;
      lsu_exc_cause = '0;
      lsu_exc_pc    = '0;
      retire_o      = 1'b0;
    end

    forward_wb_en     = rf_we;
    forward_wb_tag    = rf_we ? rd_wr_tag_wb : '0;
    forward_wb_addr   = rf_waddr;
    forward_wb_wdata  = rf_wdata;
    clr_dirty_wb_en   = rf_we;
    clr_dirty_wb_addr = rf_waddr;

    minstret_d = minstret_q + 64'(retire_o);
  end

  // State, pending-retire flag, watchdog and retire counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pend_ret_q <= 1'b0;
      tmo_cnt_q  <= '0;
      minstret_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_ret_q <= pend_ret_d;
      tmo_cnt_q  <= tmo_cnt_d;
      minstret_q <= minstret_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage with a transaction-level model
// and a per-cycle compare process.
module tb_wb_stage;
  import wb_pkg::*;

  localparam int T = 4;

  logic        clk;
  logic        reset;
  logic        rd_wr_en_wb;
  logic [2:0]  rd_wr_tag_wb;
  logic [4:0]  rd_wr_addr_wb;
  logic [31:0] rd_wr_data_wb;
  logic        lsu_en_wb;
  lsu_op_e     lsu_op_wb;
  logic [31:0] lsu_rdata_wb;
  logic        lsu_valid_wb;
  logic        lsu_err_wb;
  logic        exc_taken_wb;
  logic [31:0] pc_wb;
  logic        iretire_wb;
  logic        ready_wb;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        forward_wb_en;
  logic [2:0]  forward_wb_tag;
  logic [4:0]  forward_wb_addr;
  logic [31:0] forward_wb_wdata;
  logic        clr_dirty_wb_en;
  logic [4:0]  clr_dirty_wb_addr;
  logic        lsu_exc_o;
  logic [3:0]  lsu_exc_cause;
  logic [31:0] lsu_exc_pc;
  logic        retire_o;
  logic [63:0] minstret;

  wb_stage #(
    .TAG_WIDTH(3),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rd_wr_en_wb(rd_wr_en_wb),
    .rd_wr_tag_wb(rd_wr_tag_wb),
    .rd_wr_addr_wb(rd_wr_addr_wb),
    .rd_wr_data_wb(rd_wr_data_wb),
    .lsu_en_wb(lsu_en_wb),
    .lsu_op_wb(lsu_op_wb),
    .lsu_rdata_wb(lsu_rdata_wb),
    .lsu_valid_wb(lsu_valid_wb),
    .lsu_err_wb(lsu_err_wb),
    .exc_taken_wb(exc_taken_wb),
    .pc_wb(pc_wb),
    .iretire_wb(iretire_wb),
    .ready_wb(ready_wb),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .forward_wb_en(forward_wb_en),
    .forward_wb_tag(forward_wb_tag),
    .forward_wb_addr(forward_wb_addr),
    .forward_wb_wdata(forward_wb_wdata),
    .clr_dirty_wb_en(clr_dirty_wb_en),
    .clr_dirty_wb_addr(clr_dirty_wb_addr),
    .lsu_exc_o(lsu_exc_o),
    .lsu_exc_cause(lsu_exc_cause),
    .lsu_exc_pc(lsu_exc_pc),
    .retire_o(retire_o),
    .minstret(minstret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle, set by the model.
  logic        e_ready;
  logic        e_we;
  logic [2:0]  e_tag;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic        e_exc;
  logic [3:0]  e_cause;
  logic [31:0] e_pc;
  logic        e_ret;
  logic [63:0] mcount;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_idle();
    e_ready = 1'b1;
    e_we    = 1'b0;
    e_tag   = '0;
    e_addr  = '0;
    e_data  = '0;
    e_exc   = 1'b0;
    e_cause = '0;
    e_pc    = '0;
    e_ret   = 1'b0;
  endtask

  task automatic drive_idle();
    rd_wr_en_wb   = 1'b0;
    rd_wr_tag_wb  = '0;
    rd_wr_addr_wb = '0;
    rd_wr_data_wb = '0;
    lsu_en_wb     = 1'b0;
    lsu_op_wb     = LSU_OP_LD;
    lsu_rdata_wb  = '0;
    lsu_valid_wb  = 1'b0;
    lsu_err_wb    = 1'b0;
    exc_taken_wb  = 1'b0;
    pc_wb         = '0;
    iretire_wb    = 1'b0;
  endtask

  // Per-cycle check against the model's expectations.
  always @(negedge clk) begin
    if (reset) mcount = '0;
    chk("ready_wb", 64'(ready_wb), 64'(e_ready));
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("fwd_en", 64'(forward_wb_en), 64'(e_we));
    chk("clr_en", 64'(clr_dirty_wb_en), 64'(e_we));
    if (e_we) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(e_addr));
      chk("rf_wdata", 64'(rf_wdata), 64'(e_data));
      chk("fwd_tag", 64'(forward_wb_tag), 64'(e_tag));
      chk("fwd_addr", 64'(forward_wb_addr), 64'(e_addr));
      chk("fwd_wdata", 64'(forward_wb_wdata), 64'(e_data));
      chk("clr_addr", 64'(clr_dirty_wb_addr), 64'(e_addr));
    end
    chk("lsu_exc_o", 64'(lsu_exc_o), 64'(e_exc));
    if (e_exc) begin
      chk("exc_cause", 64'(lsu_exc_cause), 64'(e_cause));
      chk("exc_pc", 64'(lsu_exc_pc), 64'(e_pc));
    end
    chk("retire_o", 64'(retire_o), 64'(e_ret));
    chk("minstret", minstret, mcount);
    if (!reset && e_ret) mcount = mcount + 64'd1;
  end

  // One instruction: response arrives 'delay' cycles after entry
  // (-1 = never). 'cut' stops driving early (-1 = run to completion).
  task automatic instr(
    input logic rd_en, input logic [2:0] tag, input logic [4:0] addr,
    input logic [31:0] data, input logic lsu_en, input lsu_op_e op,
    input logic [31:0] rdata, input logic err, input logic exc,
    input logic [31:0] pc, input logic ret, input int delay,
    input int cut, output int low);
    int done;
    logic fault;
    logic nw;
    nw = lsu_en && !exc;
    if (!nw) begin
      done = 0; fault = 1'b0;
    end else if (delay >= 0 && delay < T) begin
      done = delay; fault = err;
    end else begin
      done = T; fault = 1'b1;
    end
    low = 0;
    for (int c = 0; c <= done && c != cut; c++) begin
      @(posedge clk); #1;
      rd_wr_en_wb   = rd_en;
      rd_wr_tag_wb  = tag;
      rd_wr_addr_wb = addr;
      rd_wr_data_wb = data;
      lsu_en_wb     = lsu_en;
      lsu_op_wb     = op;
      lsu_rdata_wb  = rdata;
      lsu_valid_wb  = (c == delay);
      lsu_err_wb    = err && (c == delay);
      exc_taken_wb  = exc;
      pc_wb         = pc;
      iretire_wb    = ret && (c == 0);
      exp_idle();
      if (c == done) begin
        e_we    = rd_en && !exc && !fault;
        e_tag   = tag;
        e_addr  = addr;
        e_data  = (lsu_en && op == LSU_OP_LD) ? rdata : data;
        e_exc   = fault;
        e_cause = (op == LSU_OP_LD) ? 4'd5 : 4'd7;
        e_pc    = pc;
        e_ret   = ret && !fault && !exc;
      end else begin
        e_ready = 1'b0;
        low++;
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive_idle();
    exp_idle();
  endtask

  int low;

  initial begin
    reset  = 1'b1;
    mcount = '0;
    drive_idle();
    exp_idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle_cycle();

    // ALU write with retire.
    instr(1, 3'd2, 5'd5, 32'h1234, 0, LSU_OP_LD, 0, 0, 0,
          32'h100, 1, -1, -1, low);
    @(negedge clk);
    chk("t1_wdata_lit", 64'(rf_wdata), 64'h1234);
    chk("t1_retire_lit", 64'(retire_o), 64'd1);
    idle_cycle();
    @(negedge clk);
    chk("t1_minstret_lit", minstret, 64'd1);

    // Load answered three cycles after entry.
    instr(1, 3'd3, 5'd7, 32'h55, 1, LSU_OP_LD, 32'hDEADBEEF, 0, 0,
          32'h104, 1, 3, -1, low);
    chk("t2_stall_lit", 64'(low), 64'd3);
    @(negedge clk);
    chk("t2_wdata_lit", 64'(rf_wdata), 64'hDEADBEEF);

    // Load answered in the entry cycle.
    instr(1, 3'd4, 5'd8, 32'h66, 1, LSU_OP_LD, 32'hCAFE0001, 0, 0,
          32'h108, 1, 0, -1, low);
    chk("t3_stall_lit", 64'(low), 64'd0);
    idle_cycle();
    @(negedge clk);
    chk("t3_minstret_lit", minstret, 64'd3);

    // Store with error response in the entry cycle.
    instr(0, 3'd0, 5'd0, 32'h0, 1, LSU_OP_ST, 0, 1, 0,
          32'h200, 1, 0, -1, low);
    @(negedge clk);
    chk("t4_cause_lit", 64'(lsu_exc_cause), 64'd7);
    chk("t4_pc_lit", 64'(lsu_exc_pc), 64'h200);

    // Store answered after two cycles, no error.
    instr(0, 3'd0, 5'd0, 32'h0, 1, LSU_OP_ST, 0, 0, 0,
          32'h204, 1, 2, -1, low);

    // Load with a late error response.
    instr(1, 3'd1, 5'd10, 32'h0, 1, LSU_OP_LD, 32'h77, 1, 0,
          32'h208, 1, 2, -1, low);

    // Stray response strobe with an ALU op.
    instr(1, 3'd5, 5'd11, 32'hA5A5, 0, LSU_OP_LD, 32'h99, 1, 0,
          32'h20C, 1, 0, -1, low);

    // Load that never answers: watchdog fires.
    instr(1, 3'd6, 5'd9, 32'h0, 1, LSU_OP_LD, 32'h11, 0, 0,
          32'h300, 1, -1, -1, low);
    chk("t5_stall_lit", 64'(low), 64'd4);
    @(negedge clk);
    chk("t5_cause_lit", 64'(lsu_exc_cause), 64'd5);
    chk("t5_ready_lit", 64'(ready_wb), 64'd1);
    idle_cycle();
    @(negedge clk);
    chk("t5_minstret_lit", minstret, 64'd5);

    // Load that already carries an exception.
    instr(1, 3'd7, 5'd12, 32'h0, 1, LSU_OP_LD, 32'h22, 0, 1,
          32'h400, 1, -1, -1, low);
    chk("t6_stall_lit", 64'(low), 64'd0);

    // Load abandoned by reset mid-wait.
    instr(1, 3'd1, 5'd13, 32'h0, 1, LSU_OP_LD, 32'h33, 0, 0,
          32'h404, 1, -1, 2, low);
    @(posedge clk); #1;
    reset = 1'b1;
    drive_idle();
    exp_idle();
    @(negedge clk);
    chk("t6_rst_minstret_lit", minstret, 64'd0);
    chk("t6_rst_ready_lit", 64'(ready_wb), 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle();

    // Normal operation after reset.
    instr(1, 3'd2, 5'd14, 32'hBEEF, 0, LSU_OP_LD, 0, 0, 0,
          32'h500, 1, -1, -1, low);
    idle_cycle();
    @(negedge clk);
    chk("t7_minstret_lit", minstret, 64'd1);
    idle_cycle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
